// File: rtl/triloc_input_packer_if.sv
//------------------------------------------------------------------------------
// Module      : triloc_input_packer_if
// Description : Operand stream and packed party vector bundle for the TriLoc packer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface triloc_input_packer_if #(
  parameter int N = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N:0]       in_data;
  logic             in_first;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   p0_input;
  logic [2*N-1:0]   p1_input;
  logic [2*N-1:0]   p2_input;
  logic [3*N+2:0]   p3_input;
  logic             fmt_err;

  modport master (
    output in_valid, in_data, in_first, out_ready,
    input  in_ready, out_valid, p0_input, p1_input, p2_input, p3_input, fmt_err
  );

  modport slave (
    input  in_valid, in_data, in_first, out_ready,
    output in_ready, out_valid, p0_input, p1_input, p2_input, p3_input, fmt_err
  );
endinterface

`default_nettype wire

// File: rtl/triloc_input_packer.sv
//------------------------------------------------------------------------------
// Module      : triloc_input_packer
// Description : Packs the nine-word trilateration operand stream into p0..p3.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module triloc_input_packer #(
  parameter int N = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  triloc_input_packer_if.slave    bus
);

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  localparam logic [3:0] C_LAST_IDX  = 4'd8;
  localparam logic [3:0] C_LAST_COORD = 4'd5;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_idx;
  logic [3:0]       w_idx_nxt;
  logic [3:0]       w_slot;
  logic [2*N-1:0]   r_p0;
  logic [2*N-1:0]   r_p1;
  logic [2*N-1:0]   r_p2;
  logic [3*N+2:0]   r_p3;
  logic             r_fmt_err;

  logic             w_accept;
  logic             w_orphan;
  logic             w_resync;
  logic             w_write;
  logic             w_sign_err;
  logic             w_last;
  logic             w_fmt_err_nxt;

  assign bus.in_ready  = (r_state == S_COLLECT);
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.p0_input  = r_p0;
  assign bus.p1_input  = r_p1;
  assign bus.p2_input  = r_p2;
  assign bus.p3_input  = r_p3;
  assign bus.fmt_err   = r_fmt_err;

  // An in_first word mid-frame restarts the frame, so it lands in slot 0.
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign w_orphan      = w_accept & (r_idx == 4'd0) & ~bus.in_first;
  assign w_resync      = w_accept & (r_idx != 4'd0) &  bus.in_first;
  assign w_write       = w_accept & ~w_orphan;
  assign w_slot        = w_resync ? 4'd0 : r_idx;
  assign w_last        = w_write & (w_slot == C_LAST_IDX);
  assign w_sign_err    = w_write & (w_slot <= C_LAST_COORD) &
                         (bus.in_data[N] != bus.in_data[N-1]);
  assign w_fmt_err_nxt = w_orphan | w_resync | w_sign_err;

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_write) begin
      w_idx_nxt = w_last ? 4'd0 : (w_slot + 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (w_last)        w_state_nxt = S_HOLD;
      S_HOLD:    if (bus.out_ready) w_state_nxt = S_COLLECT;
      default:                      w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= 4'd0;
      r_fmt_err <= 1'b0;
      r_p0      <= '0;
      r_p1      <= '0;
      r_p2      <= '0;
      r_p3      <= '0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_fmt_err <= w_fmt_err_nxt;
      if (w_write) begin
        case (w_slot)
          4'd0: r_p0[2*N-1:N]     <= bus.in_data[N-1:0];
          4'd1: r_p0[N-1:0]       <= bus.in_data[N-1:0];
          4'd2: r_p1[2*N-1:N]     <= bus.in_data[N-1:0];
          4'd3: r_p1[N-1:0]       <= bus.in_data[N-1:0];
          4'd4: r_p2[2*N-1:N]     <= bus.in_data[N-1:0];
          4'd5: r_p2[N-1:0]       <= bus.in_data[N-1:0];
          4'd6: r_p3[3*N+2:2*N+2] <= bus.in_data;
          4'd7: r_p3[2*N+1:N+1]   <= bus.in_data;
          4'd8: r_p3[N:0]         <= bus.in_data;
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_triloc_input_packer.sv
//------------------------------------------------------------------------------
// Module      : tb_triloc_input_packer
// Description : Directed self-checking bench for triloc_input_packer (N=8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_triloc_input_packer;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  triloc_input_packer_if #(.N(N)) bus ();

  triloc_input_packer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one word and returns fmt_err as seen the cycle after its handshake.
  task automatic send_word(input logic [8:0] data, input logic first, output logic fe);
    int waited;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_first = first;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    fe = bus.fmt_err;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
  endtask

  // words[80:72] is xA ... words[8:0] is rC; mask[i] is the expected fmt_err for word i.
  task automatic send_frame(input string tag, input logic [80:0] words, input logic [8:0] mask);
    logic fe;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk({tag, "_valid_before_rc"}, {31'd0, bus.out_valid}, 32'd0);
      send_word(words[(8-i)*9 +: 9], (i == 0), fe);
      chk($sformatf("%s_fmt_err_w%0d", tag, i), {31'd0, fe}, {31'd0, mask[i]});
    end
    chk({tag, "_valid_after_rc"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic chk_frame(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [26:0] e3);
    chk({tag, "_p0"}, {16'd0, bus.p0_input}, {16'd0, e0});
    chk({tag, "_p1"}, {16'd0, bus.p1_input}, {16'd0, e1});
    chk({tag, "_p2"}, {16'd0, bus.p2_input}, {16'd0, e2});
    chk({tag, "_p3"}, {5'd0, bus.p3_input}, {5'd0, e3});
  endtask

  task automatic release_frame(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_valid_released"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  // xB = 1F0 keeps the sign bit consistent while still giving p1 = F010.
  localparam logic [80:0] FRAME_A = {9'h005, 9'h1FB, 9'h1F0, 9'h010, 9'h07F,
                                     9'h180, 9'h0A0, 9'h1FF, 9'h064};
  localparam logic [80:0] FRAME_B = {9'h011, 9'h002, 9'h003, 9'h004, 9'h005,
                                     9'h006, 9'h007, 9'h008, 9'h009};
  localparam logic [80:0] FRAME_S = {9'h005, 9'h1FB, 9'h080, 9'h010, 9'h07F,
                                     9'h180, 9'h0A0, 9'h1FF, 9'h064};

  initial begin
    logic fe;
    checks = 0;
    errors = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_first  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_fmt_err",   {31'd0, bus.fmt_err},   32'd0);
    chk_frame("rst", 16'h0000, 16'h0000, 16'h0000, 27'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. Clean frame with out_ready held high
    send_frame("clean", FRAME_A, 9'b0);
    chk_frame("clean", 16'h05FB, 16'hF010, 16'h7F80, 27'h283FE64);
    release_frame("clean");

    // 2. Backpressure for ten cycles
    bus.out_ready = 1'b0;
    send_frame("bp", FRAME_A, 9'b0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_valid_%0d", c), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp_hold_ready_%0d", c), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("bp_hold_err_%0d", c), {31'd0, bus.fmt_err}, 32'd0);
    end
    chk_frame("bp", 16'h05FB, 16'hF010, 16'h7F80, 27'h283FE64);
    release_frame("bp");

    // 3. Resync: four words of a frame, then a fresh frame starting at 11
    send_word(9'h033, 1'b1, fe); chk("resync_w0_err", {31'd0, fe}, 32'd0);
    send_word(9'h044, 1'b0, fe); chk("resync_w1_err", {31'd0, fe}, 32'd0);
    send_word(9'h055, 1'b0, fe); chk("resync_w2_err", {31'd0, fe}, 32'd0);
    send_word(9'h066, 1'b0, fe); chk("resync_w3_err", {31'd0, fe}, 32'd0);
    send_frame("resync", FRAME_B, 9'b0_0000_0001);
    chk_frame("resync", 16'h1102, 16'h0304, 16'h0506, 27'h01C1009);
    release_frame("resync");

    // 4. Orphan words at idx 0 are dropped
    for (int k = 0; k < 3; k++) begin
      send_word(9'h012 + 9'(k), 1'b0, fe);
      chk($sformatf("orphan_err_%0d", k), {31'd0, fe}, 32'd1);
      chk($sformatf("orphan_novalid_%0d", k), {31'd0, bus.out_valid}, 32'd0);
    end
    send_frame("post_orphan", FRAME_A, 9'b0);
    chk_frame("post_orphan", 16'h05FB, 16'hF010, 16'h7F80, 27'h283FE64);
    release_frame("post_orphan");

    // 5. Sign-extension error on xB
    send_frame("sign", FRAME_S, 9'b0_0000_0100);
    chk_frame("sign", 16'h05FB, 16'h8010, 16'h7F80, 27'h283FE64);
    release_frame("sign");

    // 6. Reset while holding a frame
    bus.out_ready = 1'b0;
    send_frame("hold_rst", FRAME_B, 9'b0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk_frame("hold_rst", 16'h0000, 16'h0000, 16'h0000, 27'h0);
    @(negedge clk); rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send_frame("after_rst", FRAME_A, 9'b0);
    chk_frame("after_rst", 16'h05FB, 16'hF010, 16'h7F80, 27'h283FE64);
    release_frame("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
